gray_counter: RTL and testbench

Registered up/down binary counter that also presents its count in Gray code, one step per enabled cycle. It acts as the source stage for Gray-coded pointers and position encoders: each enabled step changes exactly one bit of `gray`, so downstream consumers such as CDC synchronisers or encoder-decode logic can sample it safely. The block also checks its own output, pulsing a flag if any non-load step changes a number of Gray bits other than one.

---
 rtl/gray_pkg.sv | 29 ++
 rtl/gray_step_checker.sv | 34 +++
 rtl/gray_counter.sv | 81 ++++++++
 tb/tb_gray_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter: code conversions and bit counting.
package gray_pkg;

    localparam int MAX_WIDTH = 16;
    localparam int CNT_W     = $clog2(MAX_WIDTH + 1);

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Flags any counting step whose Gray output changed a number of bits other than one.
module gray_step_checker
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gray,
    input  logic             was_step,
    output logic             step_err
);

    logic [WIDTH-1:0]     prev_gray;
    logic [MAX_WIDTH-1:0] diff;
    logic                 bad_step;

    always_comb begin
        diff            = '0;
        diff[WIDTH-1:0] = gray ^ prev_gray;
        bad_step        = was_step && (popcount(diff) != CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray <= '0;
            step_err  <= 1'b0;
        end else begin
            prev_gray <= gray;
            step_err  <= bad_step;
        end
    end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary counter with a same-edge registered Gray copy and wrap pulse.
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    output logic             step_err
);

    logic [WIDTH-1:0]     bin_q;
    logic [WIDTH-1:0]     gray_q;
    logic                 wrap_q;
    logic                 was_step_q;
    logic [WIDTH-1:0]     bin_next;
    logic [WIDTH-1:0]     gray_next;
    logic [MAX_WIDTH-1:0] gray_ext;
    logic                 wrap_next;
    logic                 step;

    always_comb begin
        bin_next  = bin_q;
        wrap_next = 1'b0;
        step      = 1'b0;
        if (load) begin
            bin_next = load_bin;
        end else if (en) begin
            step = 1'b1;
            if (up) begin
                bin_next  = bin_q + WIDTH'(1);
                wrap_next = (bin_q == '1);
            end else begin
                bin_next  = bin_q - WIDTH'(1);
                wrap_next = (bin_q == '0);
            end
        end
    end

    // Gray is derived from the next binary value so both registers load on the same edge.
    always_comb begin
        gray_ext  = bin2gray(MAX_WIDTH'(bin_next));
        gray_next = gray_ext[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q      <= '0;
            gray_q     <= '0;
            wrap_q     <= 1'b0;
            was_step_q <= 1'b0;
        end else begin
            bin_q      <= bin_next;
            gray_q     <= gray_next;
            wrap_q     <= wrap_next;
            was_step_q <= step;
        end
    end

    gray_step_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .gray     (gray_q),
        .was_step (was_step_q),
        .step_err (step_err)
    );

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed vector table, random run against a model, fault injection.
module tb_gray_counter;

    localparam int W = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         step_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_bin (load_bin),
        .bin      (bin),
        .gray     (gray),
        .wrap     (wrap),
        .step_err (step_err)
    );

    typedef struct {
        bit rst;
        bit load;
        int lb;
        bit en;
        bit up;
        int e_bin;
        int e_gray;
        bit e_wrap;
        bit e_err;
        string tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, bit r, bit ld, int lb, bit e, bit u,
                                int eb, int eg, bit ew);
        vec_t v;
        v.tag = tag; v.rst = r; v.load = ld; v.lb = lb; v.en = e; v.up = u;
        v.e_bin = eb; v.e_gray = eg; v.e_wrap = ew; v.e_err = 1'b0;
        vecs.push_back(v);
    endfunction

    // Reflected-code definition: bit i toggles every 2^(i+1) counts, offset by 2^i.
    function automatic int ref_gray(int n);
        int g = 0;
        for (int i = 0; i < W; i++) begin
            g += (((n + (1 << i)) / (1 << (i + 1))) % 2) << i;
        end
        return g;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(bit r, bit ld, int lb, bit e, bit u);
        rst = r; load = ld; load_bin = W'(lb); en = e; up = u;
        @(posedge clk);
        #1;
    endtask

    int up_bins[20];
    int up_grays[20] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0, 1, 3, 2, 6};

    int  m_bin;
    bit  m_wrap;
    bit  r_rst, r_load, r_en, r_up;
    int  r_lb;
    int  prev_gray;
    bit  prev_step;
    logic [W-1:0] forced;

    initial begin
        for (int i = 0; i < 20; i++) up_bins[i] = (i + 1) % MOD;

        add("reset0", 1, 0, 0, 0, 0, 0, 0, 0);
        add("reset1", 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            add("free_up", 0, 0, 0, 1, 1, up_bins[i], up_grays[i], i == 15);
        add("load2", 0, 1, 2, 0, 0, 2, 3, 0);
        add("down", 0, 0, 0, 1, 0, 1, 1, 0);
        add("down", 0, 0, 0, 1, 0, 0, 0, 0);
        add("down_wrap", 0, 0, 0, 1, 0, 15, 8, 1);
        add("down", 0, 0, 0, 1, 0, 14, 9, 0);
        add("load_prio", 0, 1, 9, 1, 1, 9, 13, 0);
        add("load7", 0, 1, 7, 0, 0, 7, 4, 0);
        add("flip_up", 0, 0, 0, 1, 1, 8, 12, 0);
        add("hold", 0, 0, 0, 0, 0, 8, 12, 0);
        add("flip_down", 0, 0, 0, 1, 0, 7, 4, 0);
        add("flip_up2", 0, 0, 0, 1, 1, 8, 12, 0);
        add("load11", 0, 1, 11, 0, 0, 11, 14, 0);
        add("rst_mid", 1, 1, 5, 1, 1, 0, 0, 0);
        add("after_rst", 0, 0, 0, 1, 1, 1, 1, 0);
        add("load15", 0, 1, 15, 0, 0, 15, 8, 0);
        add("max_up_wrap", 0, 0, 0, 1, 1, 0, 0, 1);
        add("hold_after_wrap", 0, 0, 0, 0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].load, vecs[i].lb, vecs[i].en, vecs[i].up);
            chk({vecs[i].tag, ".bin"},  int'(bin),      vecs[i].e_bin);
            chk({vecs[i].tag, ".gray"}, int'(gray),     vecs[i].e_gray);
            chk({vecs[i].tag, ".wrap"}, int'(wrap),     int'(vecs[i].e_wrap));
            chk({vecs[i].tag, ".err"},  int'(step_err), int'(vecs[i].e_err));
        end

        // Random run against the arithmetic model.
        drive(1, 0, 0, 0, 0);
        m_bin = 0; prev_gray = 0; prev_step = 0;
        for (int c = 0; c < 400; c++) begin
            r_rst  = ($urandom_range(0, 31) == 0);
            r_load = ($urandom_range(0, 7) == 0);
            r_en   = ($urandom_range(0, 3) != 0);
            r_up   = $urandom_range(0, 1) == 1;
            r_lb   = int'($urandom_range(0, MOD - 1));
            if (c % 97 == 50) begin
                r_rst = 0; r_load = 1; r_lb = MOD - 1;
            end
            prev_gray = int'(gray);
            drive(r_rst, r_load, r_lb, r_en, r_up);
            m_wrap = 0;
            if (r_rst) m_bin = 0;
            else if (r_load) m_bin = r_lb;
            else if (r_en) begin
                if (r_up) begin
                    m_wrap = (m_bin == MOD - 1);
                    m_bin = (m_bin + 1) % MOD;
                end else begin
                    m_wrap = (m_bin == 0);
                    m_bin = (m_bin + MOD - 1) % MOD;
                end
            end
            chk("rnd.bin",  int'(bin),      m_bin);
            chk("rnd.gray", int'(gray),     ref_gray(m_bin));
            chk("rnd.wrap", int'(wrap),     int'(m_wrap));
            chk("rnd.err",  int'(step_err), 0);
            if (!r_rst && !r_load && r_en)
                chk("rnd.one_bit_step", $countones(W'(prev_gray) ^ gray), 1);
        end

        // Fault injection: make a step's Gray value differ from the previous one in two bits.
        drive(0, 1, 5, 0, 0);
        drive(0, 0, 0, 0, 0);
        chk("fi.pre_gray", int'(gray), 7);
        drive(0, 0, 0, 1, 1);
        chk("fi.step_gray", int'(gray), 5);
        chk("fi.err_before", int'(step_err), 0);
        forced = 4'd4;
        force dut.gray_q = forced;
        drive(0, 0, 0, 0, 0);
        chk("fi.err_pulse", int'(step_err), 1);
        release dut.gray_q;
        drive(0, 0, 0, 0, 0);
        chk("fi.err_cleared", int'(step_err), 0);
        chk("fi.gray_restored", int'(gray), 5);
        drive(0, 0, 0, 0, 0);
        chk("fi.err_quiet", int'(step_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
